// File: rtl/bg_draw_pkg.sv
// Shared types and constants for the background frame drawer.
// Resolution defaults here also feed the VGA adapter defparams.
package bg_draw_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } bg_state_e;

   localparam int BG_WIDTH       = 160;
   localparam int BG_HEIGHT      = 120;
   localparam int BG_X_BITS      = 8;
   localparam int BG_Y_BITS      = 7;
   localparam int BG_COLOUR_BITS = 12;

   function automatic int bg_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/bg_pipe_delay.sv
// Fixed-depth shift register realigning scan coordinates
// with the ROM read latency.
module bg_pipe_delay #(
   parameter int DEPTH = 1,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q [DEPTH];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/bg_frame_drawer.sv
// Raster sweeper from the background ROMs to the VGA plot port.
// Define TRANSPARENT_KEY_EN to suppress plots of KEY_COLOUR pixels.
module bg_frame_drawer
   import bg_draw_pkg::*;
#(
   parameter int WIDTH       = BG_WIDTH,
   parameter int HEIGHT      = BG_HEIGHT,
   parameter int X_BITS      = BG_X_BITS,
   parameter int Y_BITS      = BG_Y_BITS,
   parameter int COLOUR_BITS = BG_COLOUR_BITS,
   parameter int NUM_IMAGES  = 2,
   parameter int ROM_LATENCY = 1,
   parameter logic [COLOUR_BITS-1:0] KEY_COLOUR = '0,
   parameter int ADDR_BITS   = bg_clog2(WIDTH * HEIGHT),
   parameter int SEL_BITS    = (bg_clog2(NUM_IMAGES) > 1) ?
                               bg_clog2(NUM_IMAGES) : 1
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              start,
   input  logic                              abort,
   input  logic [SEL_BITS-1:0]               img_sel,
   output logic [ADDR_BITS-1:0]              rom_addr,
   input  logic [NUM_IMAGES*COLOUR_BITS-1:0] rom_data,
   output logic [X_BITS-1:0]                 x,
   output logic [Y_BITS-1:0]                 y,
   output logic [COLOUR_BITS-1:0]            colour,
   output logic                              plot,
   output logic                              busy,
   output logic                              done
);

   localparam int CNT_BITS = bg_clog2(ROM_LATENCY + 1);
   localparam int PW       = 1 + X_BITS + Y_BITS;

   localparam logic [X_BITS-1:0]   X_LAST   = X_BITS'(WIDTH - 1);
   localparam logic [Y_BITS-1:0]   Y_LAST   = Y_BITS'(HEIGHT - 1);
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(ROM_LATENCY - 1);

`ifdef TRANSPARENT_KEY_EN
   localparam logic KEY_EN = 1'b1;
`else
   localparam logic KEY_EN = 1'b0;
`endif

   bg_state_e             state_q, state_d;
   logic [SEL_BITS-1:0]   img_q, img_d;
   logic [X_BITS-1:0]     sx_q, sx_d;
   logic [Y_BITS-1:0]     sy_q, sy_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic                  done_q, done_d;

   logic                  accept;
   logic                  issue;
   logic                  last_pix;
   logic                  drain_end;

   logic [PW-1:0]         pipe_d, pipe_q;
   logic                  pv;
   logic [X_BITS-1:0]     px;
   logic [Y_BITS-1:0]     py;
   logic [COLOUR_BITS-1:0] pix;

   assign last_pix = (sx_q == X_LAST) && (sy_q == Y_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (abort || last_pix) state_d = DRAIN;
         DRAIN:   if (drain_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept    = (state_q == IDLE) && start;
      issue     = (state_q == SCAN) && !abort;
      drain_end = (state_q == DRAIN) && (cnt_q == CNT_LAST);
      busy      = (state_q != IDLE);
   end

   always_comb begin
      img_d  = img_q;
      sx_d   = sx_q;
      sy_d   = sy_q;
      addr_d = addr_q;
      cnt_d  = cnt_q;
      done_d = drain_end;
      if (accept) begin
         img_d  = (int'(img_sel) < NUM_IMAGES) ? img_sel : '0;
         sx_d   = '0;
         sy_d   = '0;
         addr_d = '0;
      end else if (issue && !last_pix) begin
         // address tracks sy*WIDTH+sx without a multiplier
         addr_d = addr_q + 1'b1;
         if (sx_q == X_LAST) begin
            sx_d = '0;
            sy_d = sy_q + 1'b1;
         end else begin
            sx_d = sx_q + 1'b1;
         end
      end
      if (state_q == DRAIN) cnt_d = cnt_q + 1'b1;
      else                  cnt_d = '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         img_q  <= '0;
         sx_q   <= '0;
         sy_q   <= '0;
         addr_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         img_q  <= img_d;
         sx_q   <= sx_d;
         sy_q   <= sy_d;
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign pipe_d = issue ? {1'b1, sx_q, sy_q} : '0;

   bg_pipe_delay #(
      .DEPTH (ROM_LATENCY),
      .W     (PW)
   ) u_delay (
      .clk    (clk),
      .resetn (resetn),
      .d_i    (pipe_d),
      .q_o    (pipe_q)
   );

   assign {pv, px, py} = pipe_q;
   assign pix = rom_data[int'(img_q)*COLOUR_BITS +: COLOUR_BITS];

   always_comb begin
      x      = px;
      y      = py;
      colour = pv ? pix : '0;
      plot   = pv && !(KEY_EN && (colour == KEY_COLOUR));
   end

   assign rom_addr = addr_q;
   assign done     = done_q;

endmodule

// File: tb/tb_bg_frame_drawer.sv
// Directed bench: 4x3 frame, two instances with ROM latency 1 and 3
// sharing stimulus, each fed by its own latency-matched ROM model.
module tb_bg_frame_drawer;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;
   localparam logic [11:0] KEY = 12'd105;
`ifdef TRANSPARENT_KEY_EN
   localparam bit KEYED = 1'b1;
`else
   localparam bit KEYED = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic img_sel = 1'b0;

   always #5 clk = ~clk;

   logic [3:0]  addr1, addr3;
   logic [23:0] data1, data3;
   logic [7:0]  x1, x3;
   logic [6:0]  y1, y3;
   logic [11:0] col1, col3;
   logic        plot1, plot3, busy1, busy3, done1, done3;

   logic [3:0] r1 = '0;
   logic [3:0] r3a = '0, r3b = '0, r3c = '0;

   always @(posedge clk) begin
      r1  <= addr1;
      r3a <= addr3;
      r3b <= r3a;
      r3c <= r3b;
   end

   assign data1 = {12'd100 + {8'd0, r1}, {8'd0, r1}};
   assign data3 = {12'd100 + {8'd0, r3c}, {8'd0, r3c}};

   bg_frame_drawer #(
      .WIDTH(W), .HEIGHT(H), .X_BITS(8), .Y_BITS(7),
      .COLOUR_BITS(12), .NUM_IMAGES(2), .ROM_LATENCY(1),
      .KEY_COLOUR(KEY)
   ) u1 (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .img_sel(img_sel), .rom_addr(addr1), .rom_data(data1),
      .x(x1), .y(y1), .colour(col1), .plot(plot1),
      .busy(busy1), .done(done1)
   );

   bg_frame_drawer #(
      .WIDTH(W), .HEIGHT(H), .X_BITS(8), .Y_BITS(7),
      .COLOUR_BITS(12), .NUM_IMAGES(2), .ROM_LATENCY(3),
      .KEY_COLOUR(KEY)
   ) u3 (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .img_sel(img_sel), .rom_addr(addr3), .rom_data(data3),
      .x(x3), .y(y3), .colour(col3), .plot(plot3),
      .busy(busy3), .done(done3)
   );

   wire [33:0] o1 = {plot1, x1, y1, col1, done1, busy1, addr1};
   wire [33:0] o3 = {plot3, x3, y3, col3, done3, busy3, addr3};

   int checks = 0;
   int errors = 0;

   // expected {plot,x,y,colour,done,busy,rom_addr} in cycle c after E0;
   // nvalid pixels issued, scan stops with rom_addr = last
   function automatic logic [33:0] model(int L, int c, int img,
                                         int nvalid, int last);
      int p, endc;
      logic v, pl;
      logic [11:0] col;
      logic [7:0] xx;
      logic [6:0] yy;
      logic [3:0] a;
      p    = c - L;
      v    = (c >= L) && (p < nvalid);
      col  = v ? 12'(img * 100 + p) : 12'd0;
      xx   = v ? 8'(p % W) : 8'd0;
      yy   = v ? 7'(p / W) : 7'd0;
      pl   = v && !(KEYED && (col == KEY));
      endc = last + 1 + L;
      a    = (c < last) ? 4'(c) : 4'(last);
      return {pl, xx, yy, col, 1'(c == endc), 1'(c < endc), a};
   endfunction

   task automatic kick(input logic img);
      @(negedge clk);
      img_sel = img;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic test_reset;
      #2 resetn = 1'b0;
      #2;
      checks++;
      if (o1 !== 34'd0) begin
         errors++;
         $display("FAIL reset_u1 got %h want 0", o1);
      end
      checks++;
      if (o3 !== 34'd0) begin
         errors++;
         $display("FAIL reset_u3 got %h want 0", o3);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_frame(input logic img);
      int n1, n3, want;
      n1 = 0;
      n3 = 0;
      want = (KEYED && img == 1'b1) ? N - 1 : N;
      kick(img);
      for (int c = 0; c <= N + 5; c++) begin
         if (c > 0) @(negedge clk);
         n1 += int'(plot1);
         n3 += int'(plot3);
         checks++;
         if (o1 !== model(1, c, int'(img), N, N - 1)) begin
            errors++;
            $display("FAIL frame_u1 c=%0d got %h want %h", c, o1,
                     model(1, c, int'(img), N, N - 1));
         end
         checks++;
         if (o3 !== model(3, c, int'(img), N, N - 1)) begin
            errors++;
            $display("FAIL frame_u3 c=%0d got %h want %h", c, o3,
                     model(3, c, int'(img), N, N - 1));
         end
      end
      checks++;
      if (n1 != want || n3 != want) begin
         errors++;
         $display("FAIL frame_count got %0d/%0d want %0d", n1, n3, want);
      end
   endtask

   task automatic test_abort;
      int n1, n3;
      n1 = 0;
      n3 = 0;
      kick(1'b0);
      for (int c = 0; c <= 5 + 1 + 3 + 2; c++) begin
         if (c > 0) @(negedge clk);
         abort = (c == 5);
         n1 += int'(plot1);
         n3 += int'(plot3);
         checks++;
         if (o1 !== model(1, c, 0, 5, 5)) begin
            errors++;
            $display("FAIL abort_u1 c=%0d got %h want %h", c, o1,
                     model(1, c, 0, 5, 5));
         end
         checks++;
         if (o3 !== model(3, c, 0, 5, 5)) begin
            errors++;
            $display("FAIL abort_u3 c=%0d got %h want %h", c, o3,
                     model(3, c, 0, 5, 5));
         end
      end
      abort = 1'b0;
      checks++;
      if (n1 != 5 || n3 != 5) begin
         errors++;
         $display("FAIL abort_count got %0d/%0d want 5", n1, n3);
      end
   endtask

   // start at 4 hits both busy; at 13 only u1 is idle (done);
   // at 15 only u3 is idle (done) while u1 is already redrawing
   task automatic test_back_to_back;
      logic [33:0] e1, e3;
      kick(1'b1);
      for (int c = 0; c <= 34; c++) begin
         if (c > 0) @(negedge clk);
         start = (c == 4) || (c == 13) || (c == 15);
         e1 = (c >= 14) ? model(1, c - 14, 1, N, N - 1)
                        : model(1, c, 1, N, N - 1);
         e3 = (c >= 16) ? model(3, c - 16, 1, N, N - 1)
                        : model(3, c, 1, N, N - 1);
         checks++;
         if (o1 !== e1) begin
            errors++;
            $display("FAIL b2b_u1 c=%0d got %h want %h", c, o1, e1);
         end
         checks++;
         if (o3 !== e3) begin
            errors++;
            $display("FAIL b2b_u3 c=%0d got %h want %h", c, o3, e3);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid;
      kick(1'b1);
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) @(negedge clk);
         checks++;
         if (o1 !== model(1, c, 1, N, N - 1) ||
             o3 !== model(3, c, 1, N, N - 1)) begin
            errors++;
            $display("FAIL midrst_pre c=%0d got %h/%h", c, o1, o3);
         end
      end
      resetn = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (o1 !== 34'd0 || o3 !== 34'd0) begin
            errors++;
            $display("FAIL midrst_zero k=%0d got %h/%h want 0", k, o1, o3);
         end
         @(negedge clk);
      end
      resetn = 1'b1;
   endtask

   initial begin
      test_reset;
      test_frame(1'b1);
      test_abort;
      test_back_to_back;
      test_reset_mid;
      test_frame(1'b1);
      test_frame(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bg_frame_drawer.md
# bg_frame_drawer

Parametrised full-screen image sweeper between the background ROMs and the VGA adapter's plot port. On a `start` pulse it walks every pixel of a WIDTH×HEIGHT frame in raster order and addresses the selected one of NUM_IMAGES colour ROMs. It realigns x/y with the ROM read latency and drives `x`, `y`, `colour` and `plot` to the adapter. It replaces the per-screen mux logic in the top level and is driven by the game FSM's screen-select outputs.

## Interface
- WIDTH, 160: frame width in pixels
- HEIGHT, 120: frame height in pixels
- X_BITS, 8: width of `x`; must satisfy 2^X_BITS ≥ WIDTH
- Y_BITS, 7: width of `y`; must satisfy 2^Y_BITS ≥ HEIGHT
- COLOUR_BITS, 12: pixel colour width (4 bits per channel)
- NUM_IMAGES, 2: number of ROM images (≥1)
- ROM_LATENCY, 1: cycles from `rom_addr` to valid `rom_data` (≥1)
- KEY_COLOUR, 12'h000: transparent colour, used only when TRANSPARENT_KEY_EN is defined
- ADDR_BITS, derived as clog2(WIDTH*HEIGHT): ROM address width
- SEL_BITS, derived as max(1, clog2(NUM_IMAGES)): image select width
- clk  in  1  system clock (CLOCK_50); single clock domain
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a frame draw; sampled only in IDLE
- abort  in  1  terminate the current frame; ignored in IDLE
- img_sel  in  SEL_BITS  image to draw; latched on accepted start
- rom_addr  out  ADDR_BITS  shared address to all image ROMs
- rom_data  in  NUM_IMAGES*COLOUR_BITS  flattened ROM outputs; image i occupies bits [i*COLOUR_BITS +: COLOUR_BITS]
- x  out  X_BITS  plot column
- y  out  Y_BITS  plot row
- colour  out  COLOUR_BITS  plot colour
- plot  out  1  write strobe to the VGA adapter
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes or is aborted

## Operation
- States:
  - IDLE → SCAN on start.
  - SCAN → DRAIN after the last address is issued, or on abort.
  - DRAIN → IDLE after ROM_LATENCY cycles; `done` pulses on this exit.
- Accepted start latches `img_sel`. A value ≥ NUM_IMAGES is treated as 0.
- SCAN: the scan counters sx/sy and the address counter start at 0.
  - The address counter increments by 1 per cycle. No multiplier is used; address = sy*WIDTH + sx is maintained incrementally.
  - sx wraps from WIDTH-1 to 0, and sy then increments.
  - The last address is (WIDTH*HEIGHT)-1.
- sx, sy and a valid bit pass through a ROM_LATENCY-deep delay line. At its output, `plot` = valid, `x`/`y` = delayed coordinates, and `colour` = latched image's slice of `rom_data`.
- Abort in SCAN: stop issuing new valid entries in that cycle. In-flight entries drain and still plot. Then `done` pulses.
- `start` while busy and `abort` in IDLE are both ignored.
- `rom_addr` holds its last value outside SCAN.
- Reset mid-frame: return to IDLE immediately with no `done` and all outputs at reset values.
- Reset values: every output is 0, state is IDLE, and the delay line is cleared.

## Timing
- Start sampled high at edge E0: `busy`=1 and `rom_addr`=0 after E0.
- Pixel k's address is presented in cycle k after E0. Its `plot` with x = k mod WIDTH and y = k div WIDTH is high in cycle k+ROM_LATENCY.
- Full frame: `plot` is high for exactly WIDTH*HEIGHT consecutive cycles. `done` is high in cycle N+ROM_LATENCY (N = WIDTH*HEIGHT), and `busy` falls on that same edge.
- A start asserted while `done` is high is accepted, so back-to-back frames have one idle cycle between them.
- Abort sampled in cycle j of SCAN: pixels 0..j-1 plot, and `done` comes ROM_LATENCY cycles later.

## Configuration
- TRANSPARENT_KEY_EN defined:
  - `plot` is suppressed for any valid pixel whose colour equals KEY_COLOUR. x, y and colour still update.
  - This lets sprite images (moles, hammer) overlay a drawn background.
  - Pixel count, latency and `done` timing are unchanged.
- Undefined: every valid pixel plots and KEY_COLOUR is unused.

## Structure
- Package bg_draw_pkg holds:
  - the state enum (IDLE, SCAN, DRAIN)
  - the clog2 helper used for ADDR_BITS and SEL_BITS
  - default resolution and colour-width constants shared with the top level and the VGA defparams
- Sub-module bg_pipe_delay: a parametrised shift register of depth ROM_LATENCY carrying {valid, sx, sy}, with asynchronous active-low reset.

## Test plan
- WIDTH=4, HEIGHT=3, ROM_LATENCY=1, NUM_IMAGES=2, ROM model returning image*100+addr; start with img_sel=1 -> 12 consecutive plots with (x,y) = (0,0)…(3,2), colour = 100…111, `done` at cycle 13, `busy` low afterwards.
- Same bench with ROM_LATENCY=3 -> first plot in cycle 3, coordinate/colour pairing still exact, `done` at cycle 15.
- Abort sampled in cycle 5 -> exactly 5 plots (pixels 0–4), no plot for address 5 onward, one `done` pulse, return to IDLE.
- Start pulses while busy, and start asserted on the `done` cycle -> first is ignored, second begins a new frame with `rom_addr`=0 next cycle.
- resetn low at cycle 6 mid-frame -> all outputs 0 immediately, no `done`, the next start draws a complete frame.
- TRANSPARENT_KEY_EN with KEY_COLOUR=105 -> 11 plots, none at (1,1), `done` timing unchanged; with the macro undefined, 12 plots.
